dmem_arbiter: RTL and testbench

- Shares the single-port data SRAM between the MIPS core's load/store port and an external loader/debug port (testbench preload, memory dump).
- Sits between the core's CEN/WEN/OEN/A/ReadData2/ReadDataMem pins and the SRAM macro.
- Stalls the core while the external port owns the memory.
- Prevents starvation in both directions using a two-state priority FSM with a starvation counter and a burst counter.

---
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : External loader/debug access port of the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    // The loader side drives requests; the arbiter answers with grant and read data.
    modport master (
        output ext_req,
        output ext_we,
        output ext_addr,
        output ext_wdata,
        input  ext_gnt,
        input  ext_rvalid,
        input  ext_rdata
    );

    modport slave (
        input  ext_req,
        input  ext_we,
        input  ext_addr,
        input  ext_wdata,
        output ext_gnt,
        output ext_rvalid,
        output ext_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port data SRAM between the core load/store port
//            and an external loader port, with starvation-bounded priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 4,
    parameter int AW           = 7,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          cpu_CEN,
    input  logic          cpu_WEN,
    input  logic [AW-1:0] cpu_A,
    input  logic [DW-1:0] cpu_D,
    output logic [DW-1:0] cpu_Q,
    output logic          cpu_stall,
    // external loader side
    dmem_arbiter_if.slave ext,
    // SRAM macro side
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] Q
);

    localparam logic [0:0] c_S_CPU        = 1'b0;
    localparam logic [0:0] c_S_EXT        = 1'b1;
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_BURST_MAX    = 4'(BURST_MAX);

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_next;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_next;
    logic       r_ext_rvalid;

    logic       w_cpu_req;
    logic       w_cpu_grant;
    logic       w_ext_grant;
    logic       w_ext_wait;
    logic       w_starve_hit;
    logic       w_burst_done;

    assign w_cpu_req = ~cpu_CEN;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_CPU;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    assign w_ext_wait   = ext.ext_req & ~w_ext_grant;
    assign w_starve_hit = (r_state == c_S_CPU) & w_ext_wait
                        & ((r_starve_cnt + 4'd1) == c_STARVE_LIMIT);
    assign w_burst_done = (r_state == c_S_EXT) & w_ext_grant
                        & ((r_burst_cnt + 4'd1) == c_BURST_MAX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_CPU: begin
                if (w_starve_hit) begin
                    w_next_state = c_S_EXT;
                end
            end
            c_S_EXT: begin
                if (!ext.ext_req || w_burst_done) begin
                    w_next_state = c_S_CPU;
                end
            end
            default: w_next_state = c_S_CPU;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs: grant selection and SRAM pin mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_cpu_grant = 1'b0;
        w_ext_grant = 1'b0;
        case (r_state)
            c_S_EXT: begin
                w_ext_grant = ext.ext_req;
                w_cpu_grant = w_cpu_req & ~ext.ext_req;
            end
            default: begin
                w_cpu_grant = w_cpu_req;
                w_ext_grant = ext.ext_req & ~w_cpu_req;
            end
        endcase

        CEN = 1'b1;
        WEN = 1'b1;
        A   = '0;
        D   = '0;
        if (w_cpu_grant) begin
            CEN = 1'b0;
            WEN = cpu_WEN;
            A   = cpu_A;
            D   = cpu_D;
        end else if (w_ext_grant) begin
            CEN = 1'b0;
            WEN = ~ext.ext_we;
            A   = ext.ext_addr;
            D   = ext.ext_wdata;
        end

        cpu_stall   = w_cpu_req & ~w_cpu_grant;
        ext.ext_gnt = w_ext_grant;
    end

    // ------------------------------------------------------------------------
    // Starvation and burst counters
    // ------------------------------------------------------------------------
    // The starve count restarts when it hands priority to the external port.
    always_comb begin
        w_starve_next = 4'd0;
        if (w_ext_wait && !w_starve_hit) begin
            w_starve_next = r_starve_cnt + 4'd1;
        end

        w_burst_next = r_burst_cnt;
        if (w_next_state == c_S_CPU) begin
            w_burst_next = 4'd0;
        end else if ((r_state == c_S_EXT) && w_ext_grant) begin
            w_burst_next = r_burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
            r_burst_cnt  <= 4'd0;
            r_ext_rvalid <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_burst_cnt  <= w_burst_next;
            r_ext_rvalid <= w_ext_grant & ~ext.ext_we;
        end
    end

    // SRAM read data arrives one cycle after the access; no local storage needed.
    assign ext.ext_rvalid = r_ext_rvalid;
    assign ext.ext_rdata  = r_ext_rvalid ? Q : '0;
    assign cpu_Q          = Q;
    assign OEN            = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter, default and 1/1 parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;

    typedef struct {
        int            cyc;
        bit            gnt;
        bit            stall;
        bit            cen;
        bit            wen;
        logic [AW-1:0] a;
        logic [DW-1:0] dd;
    } exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } dat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cen [2], wen [2], er [2], ew [2];
    logic [AW-1:0] ca [2], ea [2];
    logic [DW-1:0] cd [2], ed [2];
    logic [DW-1:0] cpu_q [2], erd [2];
    logic          stall [2], eg [2], ev [2];
    logic          s_cen [2], s_wen [2], s_oen [2];
    logic [AW-1:0] s_a [2];
    logic [DW-1:0] s_d [2], s_q [2];
    logic [DW-1:0] sram [2][128];

    dmem_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

    assign if0.ext_req = er[0];  assign if0.ext_we = ew[0];
    assign if0.ext_addr = ea[0]; assign if0.ext_wdata = ed[0];
    assign if1.ext_req = er[1];  assign if1.ext_we = ew[1];
    assign if1.ext_addr = ea[1]; assign if1.ext_wdata = ed[1];
    assign eg[0] = if0.ext_gnt;  assign ev[0] = if0.ext_rvalid; assign erd[0] = if0.ext_rdata;
    assign eg[1] = if1.ext_gnt;  assign ev[1] = if1.ext_rvalid; assign erd[1] = if1.ext_rdata;

    dmem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(4), .AW(AW), .DW(DW)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_CEN(cen[0]), .cpu_WEN(wen[0]), .cpu_A(ca[0]), .cpu_D(cd[0]),
        .cpu_Q(cpu_q[0]), .cpu_stall(stall[0]),
        .ext(if0.slave),
        .CEN(s_cen[0]), .WEN(s_wen[0]), .OEN(s_oen[0]), .A(s_a[0]), .D(s_d[0]), .Q(s_q[0])
    );

    dmem_arbiter #(.STARVE_LIMIT(1), .BURST_MAX(1), .AW(AW), .DW(DW)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_CEN(cen[1]), .cpu_WEN(wen[1]), .cpu_A(ca[1]), .cpu_D(cd[1]),
        .cpu_Q(cpu_q[1]), .cpu_stall(stall[1]),
        .ext(if1.slave),
        .CEN(s_cen[1]), .WEN(s_wen[1]), .OEN(s_oen[1]), .A(s_a[1]), .D(s_d[1]), .Q(s_q[1])
    );

    // Behavioural single-port SRAM: write on the edge, read data one cycle later.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!s_cen[d]) begin
                if (!s_wen[d]) sram[d][s_a[d]] <= s_d[d];
                else           s_q[d] <= sram[d][s_a[d]];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model and scoreboard state
    // ------------------------------------------------------------------------
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            prio [2];
    int            waited [2], burst [2];
    bit            cpu_won [2], ext_won [2];
    logic [DW-1:0] mmem [2][128];
    exp_t          exp_q [2][$];
    dat_t          rd_q [2][$];
    dat_t          cexp_q [2][$];
    bit            ghist [2][4096];

    function automatic int lim_of(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(string nm, int d, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            prio[d] = 1'b0; waited[d] = 0; burst[d] = 0;
            cpu_won[d] = 1'b0; ext_won[d] = 1'b0;
            rd_q[d].delete();
        end
    endtask

    // One arbitration cycle: pick the owner from the priority holder, record
    // the expected pins, then update the memory image and priority bookkeeping.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit   creq, cw, xw;
            exp_t e;
            dat_t r;
            creq = !cen[d];
            if (prio[d]) begin xw = er[d]; cw = creq && !er[d]; end
            else         begin cw = creq;  xw = er[d] && !creq; end
            e.cyc = cyc; e.gnt = xw; e.stall = creq && !cw; e.cen = !(cw || xw);
            e.wen = 1'b1; e.a = '0; e.dd = '0;
            if (cw)      begin e.wen = wen[d]; e.a = ca[d]; e.dd = cd[d]; end
            else if (xw) begin e.wen = !ew[d]; e.a = ea[d]; e.dd = ed[d]; end
            exp_q[d].push_back(e);
            r.cyc = cyc + 1;
            if (xw && !ew[d]) begin r.data = mmem[d][ea[d]]; rd_q[d].push_back(r); end
            if (xw && ew[d])  mmem[d][ea[d]] = ed[d];
            if (cw && wen[d]) begin r.data = mmem[d][ca[d]]; cexp_q[d].push_back(r); end
            if (cw && !wen[d]) mmem[d][ca[d]] = cd[d];
            if (er[d] && !xw) waited[d]++; else waited[d] = 0;
            if (!prio[d]) begin
                if (waited[d] == lim_of(d)) begin prio[d] = 1'b1; waited[d] = 0; end
            end else begin
                if (xw) burst[d]++;
                if (!er[d] || burst[d] == lim_of(d)) begin prio[d] = 1'b0; burst[d] = 0; end
            end
            cpu_won[d] = cw; ext_won[d] = xw;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares DUT pins against queued expectations every cycle
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        dat_t r;
        bit   want;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (exp_q[d].size() > 0 && exp_q[d][0].cyc == cyc) begin
                    e = exp_q[d].pop_front();
                    chk("ext_gnt", d, 32'(eg[d]), 32'(e.gnt));
                    chk("cpu_stall", d, 32'(stall[d]), 32'(e.stall));
                    chk("CEN", d, 32'(s_cen[d]), 32'(e.cen));
                    chk("WEN", d, 32'(s_wen[d]), 32'(e.wen));
                    chk("A", d, 32'(s_a[d]), 32'(e.a));
                    chk("D", d, s_d[d], e.dd);
                end
                if (cyc < 4096) ghist[d][cyc] = eg[d];
                want = (rd_q[d].size() > 0 && rd_q[d][0].cyc == cyc);
                chk("ext_rvalid", d, 32'(ev[d]), 32'(want));
                if (want) begin
                    r = rd_q[d].pop_front();
                    chk("ext_rdata", d, erd[d], r.data);
                end
                if (cexp_q[d].size() > 0 && cexp_q[d][0].cyc == cyc) begin
                    r = cexp_q[d].pop_front();
                    chk("cpu_Q", d, cpu_q[d], r.data);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            cen[d] = 1'b1; wen[d] = 1'b1; ca[d] = '0; cd[d] = '0;
            er[d] = 1'b0;  ew[d] = 1'b0;  ea[d] = '0; ed[d] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_ext(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] wd);
        for (int d = 0; d < 2; d++) begin
            er[d] = req; ew[d] = we; ea[d] = a; ed[d] = wd;
        end
    endtask

    task automatic set_cpu(bit req, bit wr, logic [AW-1:0] a, logic [DW-1:0] wd);
        for (int d = 0; d < 2; d++) begin
            cen[d] = !req; wen[d] = !wr; ca[d] = a; cd[d] = wd;
        end
    endtask

    // A request that lost arbitration is held unchanged, as the core does by stalling.
    task automatic rand_in(int d);
        if (!(cen[d] == 1'b0 && !cpu_won[d])) begin
            cen[d] = ($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
            wen[d] = 1'($urandom_range(0, 1));
            ca[d]  = 7'($urandom_range(0, 15));
            cd[d]  = $urandom;
        end
        if (!(er[d] && !ext_won[d])) begin
            er[d] = ($urandom_range(0, 99) < 55);
            ew[d] = 1'($urandom_range(0, 1));
            ea[d] = 7'($urandom_range(0, 15));
            ed[d] = $urandom;
        end
    endtask

    function automatic logic [15:0] pattern(int d, int start, int len);
        logic [15:0] p = '0;
        for (int i = 0; i < len; i++) p[i] = ghist[d][start + i];
        return p;
    endfunction

    initial begin
        int s;
        idle_all();
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset CEN", d, 32'(s_cen[d]), 32'd1);
            chk("reset WEN", d, 32'(s_wen[d]), 32'd1);
            chk("reset A", d, 32'(s_a[d]), 32'd0);
            chk("reset D", d, s_d[d], 32'd0);
            chk("reset OEN", d, 32'(s_oen[d]), 32'd0);
            chk("reset cpu_stall", d, 32'(stall[d]), 32'd0);
            chk("reset ext_gnt", d, 32'(eg[d]), 32'd0);
            chk("reset ext_rvalid", d, 32'(ev[d]), 32'd0);
            chk("reset ext_rdata", d, erd[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Preload the whole memory through the external port.
        for (int i = 0; i < 128; i++) begin
            tick();
            set_ext(1'b1, 1'b1, 7'(i), $urandom);
            model_step();
        end

        // Ext write then read back; ext write then core load of the same word.
        tick(); set_ext(1'b1, 1'b1, 7'h05, 32'hDEADBEEF); model_step();
        tick(); set_ext(1'b1, 1'b0, 7'h05, 32'h0);        model_step();
        tick(); set_ext(1'b1, 1'b1, 7'h10, 32'h12345678); model_step();
        tick(); set_ext(1'b0, 1'b0, 7'h00, 32'h0); set_cpu(1'b1, 1'b0, 7'h10, 32'h0); model_step();
        tick(); idle_all(); model_step();

        // Full contention: 4/4 alternation on dut0, strict alternation on dut1.
        s = cyc + 1;
        for (int i = 0; i < 22; i++) begin
            tick();
            set_cpu(1'b1, 1'b0, 7'h03, 32'h0);
            set_ext(1'b1, 1'b1, 7'h03, 32'hA5A5_0000 + 32'(i));
            model_step();
        end
        // Burst cut short: ext drops after two priority grants on dut0.
        for (int i = 0; i < 2; i++) begin
            tick(); set_ext(1'b0, 1'b0, 7'h00, 32'h0); model_step();
        end
        tick(); idle_all(); model_step();
        chk("contention pattern", 0, 32'(pattern(0, s, 16)), 32'h0000F0F0);
        chk("contention pattern", 1, 32'(pattern(1, s, 16)), 32'h0000AAAA);
        chk("burst cut pattern", 0, 32'(pattern(0, s + 16, 8)), 32'h00000030);
        chk("burst cut pattern", 1, 32'(pattern(1, s + 16, 8)), 32'h0000002A);

        // Reset while an ext read is in flight.
        tick(); set_ext(1'b1, 1'b0, 7'h05, 32'h0); model_step();
        tick(); set_ext(1'b1, 1'b0, 7'h10, 32'h0); model_step();
        @(negedge clk);
        #2;
        idle_all();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async reset ext_rvalid", d, 32'(ev[d]), 32'd0);
            chk("async reset CEN", d, 32'(s_cen[d]), 32'd1);
            chk("async reset cpu_stall", d, 32'(stall[d]), 32'd0);
        end
        tick(); model_step();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            tick();
            rand_in(0);
            rand_in(1);
            model_step();
        end

        for (int i = 0; i < 3; i++) begin
            tick(); idle_all(); model_step();
        end
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("ext reads outstanding", d, 32'(rd_q[d].size()), 32'd0);
            chk("cpu reads outstanding", d, 32'(cexp_q[d].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
